// File: rtl/led_ctrl.sv
// led_ctrl - memory-mapped LED controller with global PWM dimming and
// optional per-LED blinking.
//
// Optional feature macro: LED_BLINK_EN
//   defined   : BLINK_MASK register, blink counter and blink phase exist.
//   undefined : blink phase is constant 0, addr 2 reads 0, writes ignored.
//
// Register map (unused upper bits read 0, ignored on write):
//   addr 0 : LED_VAL[7:0]            reset 0x00
//   addr 1 : DUTY[PWM_BITS-1:0]      reset all-ones (full brightness)
//   addr 2 : BLINK_MASK[7:0]         reset 0x00
//   addr 3 : STATUS (read-only)      {blink_phase, pwm_cnt}
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   wr_en    in   write strobe
//   rd_en    in   read strobe
//   addr     in   register select
//   wr_data  in   write data
//   rd_data  out  read data, valid while ready=1, else 0
//   ready    out  one-cycle acknowledge, one per accepted access
//   wfi      in   CPU in wait-for-interrupt: timers and led_bus freeze
//   led_bus  out  registered LED drive
//
// Bus handshake: any cycle with rd_en or wr_en set is an accepted access
// (no stall). ready is high for exactly the following cycle. A combined
// read+write performs the write and returns the pre-write value.
module led_ctrl #(
    parameter int PWM_BITS  = 4,
    parameter int BLINK_DIV = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [1:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        ready,
    input  logic        wfi,
    output logic [7:0]  led_bus
);

    localparam logic [PWM_BITS-1:0] DUTY_FULL = '1;

    logic [7:0]          led_val;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [7:0]          blink_mask;
    logic                blink_phase;
    logic                pwm_on;
    logic [31:0]         rd_mux;

    // Upper write-data bits are architecturally ignored.
    logic unused_bits;
    assign unused_bits = &{1'b0, wr_data};

`ifdef LED_BLINK_EN
    logic [BLINK_DIV-1:0] blink_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_mask  <= 8'h00;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (wr_en && addr == 2'd2) begin
                blink_mask <= wr_data[7:0];
            end
            if (!wfi) begin
                blink_cnt <= blink_cnt + 1'b1;
                // Phase flips on the all-ones -> 0 wrap of the counter.
                if (&blink_cnt) begin
                    blink_phase <= ~blink_phase;
                end
            end
        end
    end
`else
    localparam int unused_blink_div = BLINK_DIV;
    assign blink_mask  = 8'h00;
    assign blink_phase = 1'b0;
`endif

    // All-ones duty bypasses the compare so full brightness is truly
    // always-on; otherwise duty=d lights d of every 2^PWM_BITS cycles.
    assign pwm_on = (duty == DUTY_FULL) || (pwm_cnt < duty);

    always_comb begin
        rd_mux = '0;
        case (addr)
            2'd0: rd_mux[7:0]          = led_val;
            2'd1: rd_mux[PWM_BITS-1:0] = duty;
            2'd2: rd_mux[7:0]          = blink_mask;
            2'd3: rd_mux[PWM_BITS:0]   = {blink_phase, pwm_cnt};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_val <= 8'h00;
            duty    <= DUTY_FULL;
            pwm_cnt <= '0;
            led_bus <= 8'h00;
            ready   <= 1'b0;
            rd_data <= 32'h0;
        end else begin
            ready   <= rd_en | wr_en;
            // rd_mux reflects pre-write state, giving read-before-write.
            rd_data <= rd_en ? rd_mux : 32'h0;

            if (wr_en) begin
                case (addr)
                    2'd0:    led_val <= wr_data[7:0];
                    2'd1:    duty    <= wr_data[PWM_BITS-1:0];
                    default: ;
                endcase
            end

            // During WFI the output and PWM timer hold; register writes
            // still land and show up once wfi drops.
            if (!wfi) begin
                pwm_cnt <= pwm_cnt + 1'b1;
                led_bus <= led_val & {8{pwm_on}} & ~(blink_mask & {8{blink_phase}});
            end
        end
    end

endmodule

// File: doc/led_ctrl.md
# led_ctrl

Memory-mapped LED controller that drives the 8-bit `led_bus` consumed by the LED pad stage. It sits on the sail-core data-memory bus. It holds a software-written LED pattern, applies global PWM dimming and optional per-LED blinking, and produces a registered, glitch-free `led_bus`. While the CPU is in WFI, all internal timers stop and `led_bus` is frozen.

## Interface
Parameters:
- `PWM_BITS`, 4: duty/counter width; PWM period is 2^PWM_BITS cycles.
- `BLINK_DIV`, 24: blink counter width; `blink_phase` toggles every 2^BLINK_DIV active cycles.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `wr_en`  in  1  write strobe, sampled at rising `clk`.
- `rd_en`  in  1  read strobe, sampled at rising `clk`.
- `addr`  in  2  register select.
- `wr_data`  in  32  write data.
- `rd_data`  out  32  read data, valid while `ready`=1.
- `ready`  out  1  one-cycle access acknowledge.
- `wfi`  in  1  CPU in wait-for-interrupt.
- `led_bus`  out  8  LED drive to the pad stage.

## Operation
Register map (unused upper bits read 0 and are ignored on write):
- addr 0, `LED_VAL[7:0]`: reset 0x00.
- addr 1, `DUTY[PWM_BITS-1:0]`: reset all-ones.
- addr 2, `BLINK_MASK[7:0]`: reset 0x00.
- addr 3, `STATUS`, read-only: `{blink_phase, pwm_cnt}` packed in the low bits as `[PWM_BITS]=blink_phase`, `[PWM_BITS-1:0]=pwm_cnt`. Writes are ignored.

Counters:
- `pwm_cnt` increments by 1 each cycle with `wfi`=0 and wraps from 2^PWM_BITS−1 to 0.
- `blink_cnt` (`BLINK_DIV` bits) increments each cycle with `wfi`=0. `blink_phase` toggles on the cycle `blink_cnt` wraps from all-ones to 0.

Output term:
- `pwm_on` = 1 if `DUTY` is all-ones; otherwise `pwm_on` = (`pwm_cnt` < `DUTY`). So `DUTY`=0 means always off.
- `led_bus[i]` (registered) = `LED_VAL[i]` & `pwm_on` & ~(`BLINK_MASK[i]` & `blink_phase`).

Bus:
- An access is accepted on every cycle that has `rd_en` or `wr_en` set. There is no stall.
- `ready` pulses for exactly the following cycle, once per access. Back-to-back accesses give back-to-back `ready` pulses.
- If `rd_en` and `wr_en` are both set: the write is performed, `rd_data` returns the pre-write value, and only one `ready` pulse is produced.
- `rd_data` is 0 whenever `ready`=0.

WFI behaviour:
- While `wfi`=1, `pwm_cnt`, `blink_cnt`, `blink_phase` and `led_bus` all hold.
- Bus writes are still accepted and `ready` still pulses while `wfi`=1. The new register values reach `led_bus` only after `wfi` falls.

Reset:
- When `rst` is sampled 1, all registers, counters, `blink_phase`, `led_bus`, `ready` and `rd_data` go to their reset values on that edge. Reset values: `led_bus`=0x00, `ready`=0, `rd_data`=0.
- Reset overrides any simultaneous access; an access in the reset cycle gets no `ready`.
- `rst` overrides `wfi`.

## Timing
- Write at edge N: the register updates at N. `led_bus` reflects the new value at edge N+1, provided `wfi`=0 at N+1.
- Read at edge N: `ready`=1 and `rd_data` are valid from N until edge N+1.
- `led_bus` is computed from the register and counter values present before each edge, so it is one cycle behind the counters.
- `wfi` falling at edge M: counters resume incrementing at M, and `led_bus` updates at M.
- PWM period is 2^PWM_BITS cycles. With `PWM_BITS`=4 and `DUTY`=d (d<15), `led_bus` is high for d of every 16 cycles.

## Configuration
Macro `LED_BLINK_EN`.
- Defined: `BLINK_MASK`, `blink_cnt` and `blink_phase` are implemented as described above.
- Undefined: blink logic is not instantiated and `blink_phase` is constant 0. Addr 2 reads 0 and writes to it are ignored. The `STATUS[PWM_BITS]` bit reads 0.

## Test plan
- Reset: hold `rst` for 2 cycles → `led_bus`=0x00 and `ready`=0. Reads return addr0=0, addr1=0xF, addr2=0.
- Full brightness: with `PWM_BITS`=4, write addr0=0xA5 → `led_bus`=0xA5 from the next cycle and stays there for 32 cycles. A read of addr0 returns 0xA5 with a single `ready` pulse.
- PWM: `LED_VAL`=0xFF, `DUTY`=4 → `led_bus`=0xFF for exactly 4 of every 16 cycles and 0x00 for the other 12. `DUTY`=0 → 0x00 constantly.
- Blink (`LED_BLINK_EN` defined, `BLINK_DIV`=4): `LED_VAL`=0xFF, `BLINK_MASK`=0x0F → `led_bus` alternates between 0xFF and 0xF0 every 16 cycles. Rerun with the macro undefined → `led_bus` is 0xFF constantly and addr2 reads 0.
- WFI freeze: assert `wfi` for 20 cycles mid-PWM → `led_bus` and `STATUS` hold. A write of addr0=0x3C during WFI gets `ready` but `led_bus` is unchanged; after `wfi` falls, `led_bus`=0x3C on that edge (with `DUTY` all-ones).
- Bus corners: `rd_en` and `wr_en` together on addr0 (old 0x11, new 0x22) → `rd_data`=0x11 with one `ready` pulse, then addr0 reads 0x22. Assert `rst` during an access → no `ready`, and all state returns to reset values.
